// File: rtl/sweep_pkg.sv
// Shared constants, FSM state type and data-word packing for the sweep register file.
package sweep_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int MAX_CNT_W  = 32;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_e;

  // Packs {sweep, step} with step occupying the low cnt_w bits; callers size-cast to 2*cnt_w.
  function automatic logic [2*MAX_CNT_W-1:0] wr_word(
    input logic [MAX_CNT_W-1:0] sweep,
    input logic [MAX_CNT_W-1:0] step,
    input int                   cnt_w
  );
    return ({{MAX_CNT_W{1'b0}}, sweep} << cnt_w) | {{MAX_CNT_W{1'b0}}, step};
  endfunction

endpackage

// File: rtl/regfile32.sv
// 32-entry register file: one synchronous write port, two combinational read ports.
// Register 0 reads as zero and is never written.
module regfile32
  import sweep_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_num,
  input  logic [DW-1:0]         wr_data,
  input  logic [REG_ADDR_W-1:0] rs_num,
  input  logic [REG_ADDR_W-1:0] rt_num,
  output logic [DW-1:0]         rs_data,
  output logic [DW-1:0]         rt_data
);

  logic [DW-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en && (wr_num != '0)) begin
      regs_q[wr_num] <= wr_data;
    end
  end

  // No write bypass: a same-cycle read returns the pre-write contents.
  assign rs_data = (rs_num == '0) ? '0 : regs_q[rs_num];
  assign rt_data = (rt_num == '0) ? '0 : regs_q[rt_num];

endmodule

// File: rtl/sweep_regfile.sv
// Sweep tracker: tags each accepted write with {sweep_count, step} and reports per-sweep stats.
// S_IDLE | no sweep open      S_ACTIVE | sweep open, counting accepted writes
module sweep_regfile
  import sweep_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] regnum,
  input  logic                  done,
  input  logic [REG_ADDR_W-1:0] rs_num,
  input  logic [REG_ADDR_W-1:0] rt_num,
  output logic [2*CNT_W-1:0]    rs_data,
  output logic [2*CNT_W-1:0]    rt_data,
  output logic                  busy,
  output logic                  sweep_done,
  output logic [CNT_W-1:0]      sweep_len,
  output logic [CNT_W-1:0]      sweep_count,
  output logic [REG_ADDR_W-1:0] last_reg
);

  localparam int DW = 2 * CNT_W;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      step_q, step_d;
  logic [CNT_W-1:0]      sweep_len_q, sweep_len_d;
  logic [CNT_W-1:0]      sweep_count_q, sweep_count_d;
  logic [REG_ADDR_W-1:0] last_reg_q, last_reg_d;
  logic                  sweep_done_q, sweep_done_d;

  logic          accept;
  logic [DW-1:0] wr_data;
  logic [CNT_W-1:0] step_inc;

  assign accept   = ~done & (regnum != '0);
  assign step_inc = (&step_q) ? step_q : step_q + CNT_W'(1);
  assign wr_data  = DW'(wr_word(MAX_CNT_W'(sweep_count_q), MAX_CNT_W'(step_q), CNT_W));

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    sweep_len_d   = sweep_len_q;
    sweep_count_d = sweep_count_q;
    last_reg_d    = last_reg_q;
    sweep_done_d  = 1'b0;

    if (accept) begin
      last_reg_d = regnum;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ACTIVE;
          step_d  = step_inc;
        end
      end
      S_ACTIVE: begin
        if (done) begin
          state_d       = S_IDLE;
          sweep_len_d   = step_q;
          sweep_count_d = sweep_count_q + CNT_W'(1);
          sweep_done_d  = 1'b1;
          step_d        = '0;
        end else if (accept) begin
          step_d = step_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      step_q        <= '0;
      sweep_len_q   <= '0;
      sweep_count_q <= '0;
      last_reg_q    <= '0;
      sweep_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      sweep_len_q   <= sweep_len_d;
      sweep_count_q <= sweep_count_d;
      last_reg_q    <= last_reg_d;
      sweep_done_q  <= sweep_done_d;
    end
  end

  regfile32 #(
    .DW(DW)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (accept),
    .wr_num  (regnum),
    .wr_data (wr_data),
    .rs_num  (rs_num),
    .rt_num  (rt_num),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  assign busy        = (state_q == S_ACTIVE);
  assign sweep_done  = sweep_done_q;
  assign sweep_len   = sweep_len_q;
  assign sweep_count = sweep_count_q;
  assign last_reg    = last_reg_q;

endmodule

// File: tb/tb_sweep_regfile.sv
// Bench for sweep_regfile: a 16-bit and a 4-bit instance share stimulus and are
// checked every cycle against a sweep-level model, plus literal spot checks.
module tb_sweep_regfile;

  logic       clock = 1'b0;
  logic       reset;
  logic       done;
  logic [4:0] regnum, rs_num, rt_num;

  logic [31:0] rs16, rt16, len16_pad;
  logic [7:0]  rs4, rt4;
  logic        busy16, busy4, sd16, sd4;
  logic [15:0] len16, cnt16;
  logic [3:0]  len4, cnt4;
  logic [4:0]  last16, last4;

  int checks   = 0;
  int failures = 0;
  bit rand_rd  = 0;

  always #10 clock = ~clock;

  sweep_regfile #(.CNT_W(16)) dut16 (
    .clock(clock), .reset(reset), .regnum(regnum), .done(done),
    .rs_num(rs_num), .rt_num(rt_num), .rs_data(rs16), .rt_data(rt16),
    .busy(busy16), .sweep_done(sd16), .sweep_len(len16),
    .sweep_count(cnt16), .last_reg(last16)
  );

  sweep_regfile #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .regnum(regnum), .done(done),
    .rs_num(rs_num), .rt_num(rt_num), .rs_data(rs4), .rt_data(rt4),
    .busy(busy4), .sweep_done(sd4), .sweep_len(len4),
    .sweep_count(cnt4), .last_reg(last4)
  );

  assign len16_pad = {16'h0, len16};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model, index 0 = 16-bit counters, index 1 = 4-bit counters.
  logic [31:0] mreg [2][32];
  bit          mopen [2];
  bit          mpulse [2];
  int          mstep [2];
  int          mlen [2];
  int          mcnt [2];
  int          mlast;
  bit          model_valid = 0;

  function automatic int wof(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      model_valid <= 1'b1;
      mlast       <= 0;
      for (int k = 0; k < 2; k++) begin
        mopen[k]  <= 1'b0;
        mpulse[k] <= 1'b0;
        mstep[k]  <= 0;
        mlen[k]   <= 0;
        mcnt[k]   <= 0;
        for (int r = 0; r < 32; r++) mreg[k][r] <= 32'h0;
      end
    end else begin
      if (!done && regnum != 0) mlast <= int'(regnum);
      for (int k = 0; k < 2; k++) begin
        int mask;
        mask = (1 << wof(k)) - 1;
        mpulse[k] <= 1'b0;
        if (mopen[k] && done) begin
          mlen[k]   <= mstep[k];
          mcnt[k]   <= (mcnt[k] + 1) & mask;
          mpulse[k] <= 1'b1;
          mstep[k]  <= 0;
          mopen[k]  <= 1'b0;
        end else if (!done && regnum != 0) begin
          mreg[k][regnum] <= 32'((mcnt[k] << wof(k)) | mstep[k]);
          mstep[k]        <= (mstep[k] + 1 > mask) ? mask : mstep[k] + 1;
          mopen[k]        <= 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (model_valid) begin
      chk("busy16", 64'(busy16), 64'(mopen[0]));
      chk("busy4", 64'(busy4), 64'(mopen[1]));
      chk("sweep_done16", 64'(sd16), 64'(mpulse[0]));
      chk("sweep_done4", 64'(sd4), 64'(mpulse[1]));
      chk("sweep_len16", 64'(len16), 64'(mlen[0]));
      chk("sweep_len4", 64'(len4), 64'(mlen[1]));
      chk("sweep_count16", 64'(cnt16), 64'(mcnt[0]));
      chk("sweep_count4", 64'(cnt4), 64'(mcnt[1]));
      chk("last_reg16", 64'(last16), 64'(mlast));
      chk("last_reg4", 64'(last4), 64'(mlast));
      chk("rs_data16", 64'(rs16), 64'(mreg[0][rs_num]));
      chk("rt_data16", 64'(rt16), 64'(mreg[0][rt_num]));
      chk("rs_data4", 64'(rs4), 64'(mreg[1][rs_num]));
      chk("rt_data4", 64'(rt4), 64'(mreg[1][rt_num]));
    end
  end

  // One stimulus cycle: drive inputs, then move to just after the next falling edge.
  task automatic cyc(input logic [4:0] rn, input logic dn);
    regnum = rn;
    done   = dn;
    if (rand_rd) begin
      rs_num = 5'($urandom_range(0, 31));
      rt_num = 5'($urandom_range(0, 31));
    end
    @(negedge clock);
    #2;
  endtask

  task automatic rd16(input logic [4:0] n, input logic [31:0] exp, input string nm);
    rs_num = n;
    rt_num = n;
    #1;
    chk(nm, 64'(rs16), 64'(exp));
    chk({nm, "_rt"}, 64'(rt16), 64'(exp));
    @(negedge clock);
    #2;
  endtask

  task automatic rand_sweep();
    int n, g;
    cyc(5'($urandom_range(1, 31)), 1'b0);
    n = $urandom_range(0, 5);
    for (int i = 0; i < n; i++) cyc(5'($urandom_range(0, 31)), 1'b0);
    cyc(5'($urandom_range(0, 31)), 1'b1);
    g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++) cyc(5'($urandom_range(0, 31)), 1'b1);
  endtask

  initial begin
    logic [31:0] down_exp [5];
    down_exp = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4};
    reset  = 1'b1;
    done   = 1'b1;
    regnum = 5'd0;
    rs_num = 5'd0;
    rt_num = 5'd0;
    repeat (2) @(negedge clock);
    #2;
    chk("reset_busy", 64'(busy16), 64'(0));
    chk("reset_count", 64'(cnt16), 64'(0));
    reset = 1'b0;

    // Down sweep 8..4
    for (int i = 0; i < 5; i++) cyc(5'(8 - i), 1'b0);
    cyc(5'd0, 1'b1);
    chk("down_pulse", 64'(sd16), 64'(1));
    chk("down_len", 64'(len16), 64'(5));
    chk("down_count", 64'(cnt16), 64'(1));
    chk("down_last", 64'(last16), 64'(4));
    for (int i = 0; i < 5; i++) rd16(5'(8 - i), down_exp[i], "down_reg");

    // Short second sweep; writes presented with done high are dropped
    cyc(5'd8, 1'b0);
    for (int i = 9; i <= 12; i++) cyc(5'(i), 1'b1);
    chk("short_len", 64'(len16_pad), 64'(1));
    chk("short_count", 64'(cnt16), 64'(2));
    rd16(5'd8, 32'h0001_0000, "short_reg8");
    for (int i = 9; i <= 12; i++) rd16(5'(i), 32'h0, "short_unwritten");

    // Register 0 filtering
    for (int i = 0; i < 5; i++) begin
      cyc(5'd0, 1'b0);
      chk("r0_idle_busy", 64'(busy16), 64'(0));
    end
    rd16(5'd0, 32'h0, "r0_read");
    cyc(5'd8, 1'b0);
    cyc(5'd0, 1'b0);
    cyc(5'd7, 1'b0);
    cyc(5'd0, 1'b1);
    chk("r0_len", 64'(len16), 64'(2));
    rd16(5'd7, 32'h0002_0001, "r0_reg7");

    // Reset mid-sweep
    cyc(5'd8, 1'b0);
    cyc(5'd7, 1'b0);
    reset = 1'b1;
    cyc(5'd6, 1'b0);
    reset = 1'b0;
    done  = 1'b1;
    chk("midrst_pulse", 64'(sd16), 64'(0));
    chk("midrst_count", 64'(cnt16), 64'(0));
    chk("midrst_busy", 64'(busy16), 64'(0));
    rd16(5'd8, 32'h0, "midrst_reg8");
    rd16(5'd7, 32'h0, "midrst_reg7");
    rd16(5'd6, 32'h0, "midrst_reg6");

    // Read during write of register 5
    cyc(5'd3, 1'b0);
    cyc(5'd5, 1'b0);
    regnum = 5'd5;
    done   = 1'b0;
    rs_num = 5'd5;
    rt_num = 5'd5;
    #1;
    chk("rdw_old", 64'(rs16), 64'(32'h1));
    @(negedge clock);
    #2;
    chk("rdw_new", 64'(rs16), 64'(32'h2));
    cyc(5'd0, 1'b1);

    // Counter limits
    rand_rd = 1;
    for (int i = 0; i < 17; i++) cyc(5'($urandom_range(1, 31)), 1'b0);
    cyc(5'd0, 1'b1);
    chk("sat_len4", 64'(len4), 64'(15));
    chk("sat_len16", 64'(len16), 64'(17));
    for (int s = 0; s < 14; s++) rand_sweep();
    chk("wrap_count4", 64'(cnt4), 64'(0));
    chk("wrap_count16", 64'(cnt16), 64'(16));

    // Free-running random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) < 3);
      cyc(5'($urandom_range(0, 31)), 1'($urandom_range(0, 99) < 30));
    end
    reset = 1'b0;
    cyc(5'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
